// File: rtl/ntt_pkg.sv
// ntt_pkg: shared Goldilocks field constants and pipeline stage record for the NTT multipliers.
package ntt_pkg;
  localparam int P_WIDTH = 64;
  localparam int LAT = 4;
  localparam logic [63:0] P_MOD = 64'hFFFFFFFF00000001;
  localparam logic [63:0] EPS = 64'h00000000FFFFFFFF;
  typedef struct packed {
    logic [P_WIDTH-1:0] data;
    logic byp;
    logic vld;
  } stage_t;
endpackage

// File: rtl/goldilocks_reduce.sv
// goldilocks_reduce: two registered steps folding a 128-bit product into canonical [0, p-1].
module goldilocks_reduce
  import ntt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*P_WIDTH-1:0] prod,
  input  logic                 byp,
  input  logic                 vld,
  output logic [P_WIDTH-1:0]   y,
  output logic                 y_vld
);
  stage_t s3_q, s3_d;
  logic [P_WIDTH-1:0] u_q, u_d, y_q, y_d, a0, diff, r1, r2;
  logic [31:0] a1, a2;
  logic borrow, y_vld_q, y_vld_d;
  logic [P_WIDTH:0] sum;
  // 2^64 = EPS and 2^96 = -1 (mod p), so prod = a0 - a2 + a1*EPS
  always_comb begin
    a0 = prod[63:0];
    a1 = prod[95:64];
    a2 = prod[127:96];
    {borrow, diff} = {1'b0, a0} - {33'b0, a2};
    s3_d = en ? stage_t'{data: byp ? a0 : (borrow ? diff - EPS : diff), byp: byp, vld: vld} : s3_q;
    u_d = en ? (byp ? '0 : {32'b0, a1} * EPS) : u_q;
    sum = {1'b0, s3_q.data} + {1'b0, u_q};
    r1 = sum[64] ? sum[63:0] + EPS : sum[63:0];
    r2 = r1 >= P_MOD ? r1 - P_MOD : r1;
    y_d = en ? (s3_q.byp ? s3_q.data : r2) : y_q;
    y_vld_d = en ? s3_q.vld : y_vld_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_q <= '0;
      u_q <= '0;
      y_q <= '0;
      y_vld_q <= 1'b0;
    end else begin
      s3_q <= s3_d;
      u_q <= u_d;
      y_q <= y_d;
      y_vld_q <= y_vld_d;
    end
  end
  assign y = y_q;
  assign y_vld = y_vld_q;
endmodule

// File: rtl/horizontal_tf_mul_row1.sv
// horizontal_tf_mul_row1: 4-stage Goldilocks multiply of butterfly output by row-1 twiddle, bypassed when stage_counter != 0.
module horizontal_tf_mul_row1 #(
  parameter int P_WIDTH = 64,
  parameter int SC_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CEN,
  input  logic [SC_WIDTH-1:0] stage_counter,
  input  logic                in_valid,
  input  logic [P_WIDTH-1:0]  A,
  input  logic [P_WIDTH-1:0]  TF,
  output logic [P_WIDTH-1:0]  Y,
  output logic                out_valid
);
  import ntt_pkg::*;
  stage_t s1_q, s1_d;
  logic [P_WIDTH-1:0] tf1_q, tf1_d;
  logic [2*P_WIDTH-1:0] prod_q, prod_d;
  logic byp2_q, byp2_d, vld2_q, vld2_d, en;
  always_comb begin
    en = ~CEN;
    s1_d = en ? stage_t'{data: A, byp: stage_counter != '0, vld: in_valid} : s1_q;
    tf1_d = en ? TF : tf1_q;
    prod_d = en ? (s1_q.byp ? {{P_WIDTH{1'b0}}, s1_q.data}
                            : {{P_WIDTH{1'b0}}, s1_q.data} * {{P_WIDTH{1'b0}}, tf1_q}) : prod_q;
    byp2_d = en ? s1_q.byp : byp2_q;
    vld2_d = en ? s1_q.vld : vld2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      tf1_q <= '0;
      prod_q <= '0;
      byp2_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      tf1_q <= tf1_d;
      prod_q <= prod_d;
      byp2_q <= byp2_d;
      vld2_q <= vld2_d;
    end
  end
  goldilocks_reduce u_reduce (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .prod  (prod_q),
    .byp   (byp2_q),
    .vld   (vld2_q),
    .y     (Y),
    .y_vld (out_valid)
  );
endmodule
